bench_run_ctrl: RTL and testbench

- Sequences one benchmark run of the pipelined RISC-V core (two-bit-predictor variant) inside the top-level test harness.
- Holds the core in reset, releases it, and counts cycles, branch/jump instructions and branch mispredictions (flushes) from the core's probe signals.
- Detects program end by a halt self-loop instruction, drains the pipeline, then freezes the counters and flags completion or timeout.

---
 rtl/bench_run_ctrl.sv | 109 ++++++++++
 tb/tb_bench_run_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bench_run_ctrl.sv
// bench_run_ctrl: sequences one core benchmark run and counts cycles, branches and mispredictions.
module bench_run_ctrl #(
   parameter int          CNT_W        = 32,
   parameter int          RST_CYCLES   = 4,
   parameter logic [31:0] HALT_INSTR   = 32'h0000_006F,
   parameter int          HALT_HOLD    = 8,
   parameter int          DRAIN_CYCLES = 4,
   parameter int          TIMEOUT      = 1000000
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             br_miss_i,
   input  logic             br_instr_i,
   input  logic [31:0]      instr_i,
   output logic             core_rst_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             timeout_o,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic [CNT_W-1:0] br_cnt_o,
   output logic [CNT_W-1:0] miss_cnt_o
);
   typedef enum logic [2:0] {IDLE, RESET, RUN, DRAIN, DONE} state_t;
   state_t state, state_n;
   logic [31:0] ph, ph_n, hc, hc_n, halt_n;
   logic [CNT_W-1:0] cyc_n, br_n, miss_n;
   logic tmo_n;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
      return (en && c != '1) ? c + 1'b1 : c;
   endfunction

   // flushed fetches are wrong-path, so they neither extend nor break a halt streak
   assign halt_n = br_miss_i ? hc : (instr_i == HALT_INSTR ? hc + 1 : '0);

   always_comb begin
      state_n = state;
      ph_n    = ph;
      hc_n    = hc;
      cyc_n   = cycle_cnt_o;
      br_n    = br_cnt_o;
      miss_n  = miss_cnt_o;
      tmo_n   = timeout_o;
      case (state)
         IDLE, DONE: if (start_i) begin
            state_n = RESET;
            ph_n    = '0;
            hc_n    = '0;
            cyc_n   = '0;
            br_n    = '0;
            miss_n  = '0;
            tmo_n   = 1'b0;
         end
         RESET: begin
            ph_n = ph + 1;
            if (ph == RST_CYCLES - 1) begin
               state_n = RUN;
               ph_n    = '0;
            end
         end
         default: begin
            cyc_n  = sat_inc(cycle_cnt_o, 1'b1);
            br_n   = sat_inc(br_cnt_o, br_instr_i);
            miss_n = sat_inc(miss_cnt_o, br_miss_i);
            ph_n   = ph + 1;
            if (state == RUN) begin
               hc_n = halt_n;
               if (halt_n == HALT_HOLD) begin
                  if (DRAIN_CYCLES == 0) state_n = DONE;
                  else state_n = DRAIN;
                  ph_n = '0;
               end else if (ph == TIMEOUT - 1) begin
                  state_n = DONE;
                  tmo_n   = 1'b1;
               end
            end else if (ph == DRAIN_CYCLES - 1) begin
               state_n = DONE;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         ph          <= '0;
         hc          <= '0;
         cycle_cnt_o <= '0;
         br_cnt_o    <= '0;
         miss_cnt_o  <= '0;
         timeout_o   <= 1'b0;
         core_rst_o  <= 1'b1;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
      end else begin
         state       <= state_n;
         ph          <= ph_n;
         hc          <= hc_n;
         cycle_cnt_o <= cyc_n;
         br_cnt_o    <= br_n;
         miss_cnt_o  <= miss_n;
         timeout_o   <= tmo_n;
         core_rst_o  <= state_n != RUN;
         busy_o      <= state_n == RESET || state_n == RUN || state_n == DRAIN;
         done_o      <= state_n == DONE;
      end
   end
endmodule

// File: tb/tb_bench_run_ctrl.sv
// tb_bench_run_ctrl: randomized run-level checks of bench_run_ctrl against a per-run scenario model.
module tb_bench_run_ctrl;
   localparam logic [31:0] HALT = 32'h0000_006F;
   localparam int TO = 50;
   localparam int N = 64;

   logic clk = 1'b0;
   logic rst, start, br_miss, br_instr;
   logic [31:0] instr;
   logic core_rst, busy, done, tmo, core_rst_s, busy_s, done_s, tmo_s;
   logic [31:0] cyc, br, miss;
   logic [3:0] cyc_s, br_s, miss_s;

   int n_chk = 0, n_fail = 0;
   bit s_br[N], s_miss[N];
   logic [31:0] s_ins[N];

   bench_run_ctrl #(.TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .br_miss_i(br_miss), .br_instr_i(br_instr),
      .instr_i(instr), .core_rst_o(core_rst), .busy_o(busy), .done_o(done), .timeout_o(tmo),
      .cycle_cnt_o(cyc), .br_cnt_o(br), .miss_cnt_o(miss));

   bench_run_ctrl #(.CNT_W(4), .TIMEOUT(TO)) dut_s (
      .clk_i(clk), .rst_i(rst), .start_i(start), .br_miss_i(br_miss), .br_instr_i(br_instr),
      .instr_i(instr), .core_rst_o(core_rst_s), .busy_o(busy_s), .done_o(done_s), .timeout_o(tmo_s),
      .cycle_cnt_o(cyc_s), .br_cnt_o(br_s), .miss_cnt_o(miss_s));

   always #5 clk = ~clk;

   function automatic int sat4(input int v);
      return v > 15 ? 15 : v;
   endfunction

   task automatic fill(input int halt_at, input int p_br, input int p_miss);
      for (int i = 0; i < N; i++) begin
         logic [31:0] r;
         r = $urandom;
         if (r == HALT) r = 32'h13;
         s_br[i]   = $urandom_range(0, 99) < p_br;
         s_miss[i] = $urandom_range(0, 99) < p_miss;
         s_ins[i]  = i >= halt_at ? HALT : r;
      end
   endtask

   task automatic junk();
      br_instr = 1'($urandom_range(0, 1));
      br_miss  = 1'($urandom_range(0, 1));
      instr    = $urandom_range(0, 1) ? HALT : $urandom;
   endtask

   // Scenario model: walk the run cycle by cycle, end on a clean halt streak or the cycle limit, then drain.
   task automatic model(output int e_cyc, output int e_br, output int e_miss, output bit e_to);
      int streak, k;
      bit halted;
      streak = 0; k = 0; halted = 0; e_cyc = 0; e_br = 0; e_miss = 0; e_to = 0;
      while (k < N) begin
         e_cyc++; e_br += int'(s_br[k]); e_miss += int'(s_miss[k]);
         if (!s_miss[k]) streak = s_ins[k] == HALT ? streak + 1 : 0;
         k++;
         if (streak == 8) begin halted = 1; break; end
         if (e_cyc == TO) begin e_to = 1; break; end
      end
      if (halted)
         for (int d = 0; d < 4 && k < N; d++) begin
            e_cyc++; e_br += int'(s_br[k]); e_miss += int'(s_miss[k]); k++;
         end
   endtask

   task automatic do_run(input string name, output int run_len);
      int e_cyc, e_br, e_miss, n, k;
      bit e_to;
      model(e_cyc, e_br, e_miss, e_to);
      @(negedge clk); start = 1'b1; junk();
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      n_chk++;
      if (cyc !== 0 || br !== 0 || miss !== 0 || tmo !== 1'b0) begin
         n_fail++; $display("FAIL %s clear: cyc=%0d br=%0d miss=%0d to=%0b want 0", name, cyc, br, miss, tmo);
      end
      n = 0;
      while (core_rst && n < 20) begin
         n_chk++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL %s reset_busy: busy=%0b done=%0b want 1/0", name, busy, done);
         end
         n++; junk();
         @(posedge clk); @(negedge clk);
      end
      n_chk++;
      if (n != 4) begin n_fail++; $display("FAIL %s reset_len: got %0d want 4", name, n); end
      k = 0;
      while (!done && k < N) begin
         br_instr = s_br[k]; br_miss = s_miss[k]; instr = s_ins[k]; k++;
         @(posedge clk); @(negedge clk);
      end
      run_len = k;
      n_chk++;
      if (done !== 1'b1 || busy !== 1'b0 || core_rst !== 1'b1) begin
         n_fail++; $display("FAIL %s done_flags: done=%0b busy=%0b core_rst=%0b want 1/0/1", name, done, busy, core_rst);
      end
      n_chk++;
      if (k != e_cyc) begin n_fail++; $display("FAIL %s run_len: got %0d want %0d", name, k, e_cyc); end
      for (int r = 0; r < 2; r++) begin
         n_chk++;
         if (cyc !== e_cyc || br !== e_br || miss !== e_miss || tmo !== e_to) begin
            n_fail++; $display("FAIL %s counters(pass %0d): cyc=%0d br=%0d miss=%0d to=%0b want %0d/%0d/%0d/%0b",
                               name, r, cyc, br, miss, tmo, e_cyc, e_br, e_miss, e_to);
         end
         n_chk++;
         if (cyc_s !== sat4(e_cyc) || br_s !== sat4(e_br) || miss_s !== sat4(e_miss) || tmo_s !== e_to) begin
            n_fail++; $display("FAIL %s sat_counters(pass %0d): cyc=%0d br=%0d miss=%0d to=%0b want %0d/%0d/%0d/%0b",
                               name, r, cyc_s, br_s, miss_s, tmo_s, sat4(e_cyc), sat4(e_br), sat4(e_miss), e_to);
         end
         for (int j = 0; j < 3; j++) begin junk(); @(posedge clk); @(negedge clk); end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; br_miss = 1'b0; br_instr = 1'b0; instr = 32'h13;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (core_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || tmo !== 1'b0 || cyc !== 0 || br !== 0 || miss !== 0) begin
         n_fail++; $display("FAIL reset: core_rst=%0b busy=%0b done=%0b to=%0b cyc=%0d br=%0d miss=%0d want 1/0/0/0/0/0/0",
                            core_rst, busy, done, tmo, cyc, br, miss);
      end
      rst = 1'b0;
   endtask

   task automatic test_halt();
      int len;
      fill(9, 0, 0);
      do_run("halt", len);
      n_chk++;
      if (cyc !== 21) begin n_fail++; $display("FAIL halt_cycles: got %0d want 21", cyc); end
   endtask

   task automatic test_events();
      int len;
      fill(10, 0, 0);
      foreach (s_br[i]) if (i inside {0, 2, 3, 5, 7, 9}) s_br[i] = 1'b1;
      s_miss[4] = 1'b1; s_miss[8] = 1'b1;
      do_run("events", len);
      n_chk++;
      if (br !== 6 || miss !== 2) begin n_fail++; $display("FAIL events: br=%0d miss=%0d want 6/2", br, miss); end
   endtask

   task automatic test_halt_filter();
      int len;
      fill(N, 0, 0);
      foreach (s_ins[i]) if (i inside {1, 3, 4, 5, 6, 7, 9, 10, [12:20]}) s_ins[i] = HALT;
      s_miss[2] = 1'b1; s_miss[5] = 1'b1; s_miss[11] = 1'b1;
      do_run("halt_filter", len);
      n_chk++;
      if (len != 22) begin n_fail++; $display("FAIL halt_filter_len: got %0d want 22", len); end
   endtask

   task automatic test_timeout();
      int len;
      fill(N, 30, 20);
      do_run("timeout", len);
      n_chk++;
      if (cyc !== TO || tmo !== 1'b1) begin n_fail++; $display("FAIL timeout: cyc=%0d to=%0b want %0d/1", cyc, tmo, TO); end
   endtask

   task automatic test_back_to_back();
      int len;
      fill(3, 50, 30);
      do_run("back_to_back", len);
   endtask

   task automatic test_random();
      int len;
      for (int t = 0; t < 6; t++) begin
         fill($urandom_range(0, 60), $urandom_range(0, 100), $urandom_range(0, 40));
         do_run($sformatf("random%0d", t), len);
      end
   endtask

   task automatic test_saturation();
      int len;
      fill(20, 0, 0);
      foreach (s_br[i]) s_br[i] = i < 20;
      do_run("saturation", len);
      n_chk++;
      if (br_s !== 4'd15 || br !== 20) begin n_fail++; $display("FAIL saturation: br_s=%0d br=%0d want 15/20", br_s, br); end
   endtask

   task automatic test_mid_reset();
      int n;
      @(negedge clk); start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0; br_instr = 1'b1; br_miss = 1'b1; instr = 32'h13;
      n = 0;
      while (core_rst && n < 20) begin n++; @(posedge clk); @(negedge clk); end
      repeat (5) begin @(posedge clk); @(negedge clk); end
      n_chk++;
      if (cyc !== 5 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_pre: cyc=%0d busy=%0b want 5/1", cyc, busy); end
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0; br_instr = 1'b0; br_miss = 1'b0;
      n_chk++;
      if (core_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || cyc !== 0 || br !== 0 || miss !== 0 || br_s !== 0) begin
         n_fail++; $display("FAIL mid_reset: core_rst=%0b busy=%0b done=%0b cyc=%0d br=%0d miss=%0d want 1/0/0/0/0/0",
                            core_rst, busy, done, cyc, br, miss);
      end
   endtask

   initial begin
      test_reset();
      test_halt();
      test_events();
      test_halt_filter();
      test_timeout();
      test_back_to_back();
      test_random();
      test_saturation();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
